// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, drives the imem address
// and registers each fetched word into a single-entry valid/ready stage.
module fetch_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          MEM_SIZE = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        redirect_en,
    input  logic [63:0] redirect_pc,
    output logic [63:0] mem_addr,
    input  logic [31:0] mem_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_exc_en,
    output logic [3:0]  out_exc_code,
    output logic [63:0] out_exc_val
);

    typedef enum logic {RUN, PARKED} state_t;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [61:0] WORDS = 62'(MEM_SIZE);

    state_t      state, state_d;
    logic [63:0] fetch_pc, pc_d;
    logic        valid_d;
    logic [63:0] opc_d;
    logic [31:0] instr_d;
    logic        exc_en_d;
    logic [3:0]  exc_code_d;
    logic [63:0] exc_val_d;

    logic misaligned, out_of_range, load;

    assign mem_addr     = fetch_pc;
    assign misaligned   = fetch_pc[1:0] != 2'b00;
    assign out_of_range = fetch_pc[63:2] >= WORDS;
    assign load         = (state == RUN) && fetch_en &&
                          (!out_valid || out_ready) && !redirect_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            fetch_pc     <= RESET_PC;
            out_valid    <= 1'b0;
            out_pc       <= 64'h0;
            out_instr    <= NOP;
            out_exc_en   <= 1'b0;
            out_exc_code <= 4'h0;
            out_exc_val  <= 64'h0;
        end else begin
            state        <= state_d;
            fetch_pc     <= pc_d;
            out_valid    <= valid_d;
            out_pc       <= opc_d;
            out_instr    <= instr_d;
            out_exc_en   <= exc_en_d;
            out_exc_code <= exc_code_d;
            out_exc_val  <= exc_val_d;
        end
    end

    always_comb begin
        state_d    = state;
        pc_d       = fetch_pc;
        valid_d    = out_valid;
        opc_d      = out_pc;
        instr_d    = out_instr;
        exc_en_d   = out_exc_en;
        exc_code_d = out_exc_code;
        exc_val_d  = out_exc_val;
        if (redirect_en) begin
            // a same-cycle handshake is a flush, not a consumption
            state_d = RUN;
            pc_d    = redirect_pc;
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            opc_d   = fetch_pc;
            if (misaligned || out_of_range) begin
                // park on the faulting PC so it is reported only once
                state_d    = PARKED;
                instr_d    = NOP;
                exc_en_d   = 1'b1;
                exc_code_d = misaligned ? 4'd0 : 4'd1;
                exc_val_d  = fetch_pc;
            end else begin
                instr_d    = mem_instr;
                exc_en_d   = 1'b0;
                exc_code_d = 4'd0;
                exc_val_d  = 64'h0;
                pc_d       = fetch_pc + 64'd4;
            end
        end else if (out_valid && out_ready) begin
            valid_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus a randomized run
// checked against a transaction-level model of the fetch rules.
module tb_fetch_ctrl;

    localparam int MEM_SIZE = 2048;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        exc_en;
        logic [3:0]  code;
        logic [63:0] val;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_en = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic [63:0] mem_addr;
    logic [31:0] mem_instr;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_exc_en;
    logic [3:0]  out_exc_code;
    logic [63:0] out_exc_val;

    logic [31:0] mem [MEM_SIZE];
    int checks = 0;
    int errors = 0;

    // model state
    logic [63:0] m_pc;
    logic        m_valid;
    logic        m_parked;
    entry_t      m_e;

    always #5 clk = ~clk;

    assign mem_instr = mem[mem_addr[12:2]];

    fetch_ctrl #(.RESET_PC(64'h0), .MEM_SIZE(MEM_SIZE)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .mem_addr(mem_addr), .mem_instr(mem_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr),
        .out_exc_en(out_exc_en), .out_exc_code(out_exc_code),
        .out_exc_val(out_exc_val)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic entry_t fetch_of(input logic [63:0] pc);
        entry_t e;
        e.pc = pc;
        if (pc % 4 != 0) begin
            e.instr = 32'h13; e.exc_en = 1'b1; e.code = 4'd0; e.val = pc;
        end else if (pc / 4 >= MEM_SIZE) begin
            e.instr = 32'h13; e.exc_en = 1'b1; e.code = 4'd1; e.val = pc;
        end else begin
            e.instr = mem[pc / 4]; e.exc_en = 1'b0; e.code = 4'd0; e.val = 0;
        end
        return e;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, mem_addr} !== {1'b0, 64'h0}) begin
            errors++;
            $display("FAIL reset_valid_addr got %b/%h exp 0/0",
                     out_valid, mem_addr);
        end
        checks++;
        if ({out_pc, out_instr, out_exc_en, out_exc_code, out_exc_val}
            !== {64'h0, 32'h13, 1'b0, 4'h0, 64'h0}) begin
            errors++;
            $display("FAIL reset_fields got pc %h instr %h exc %b/%h/%h",
                     out_pc, out_instr, out_exc_en, out_exc_code,
                     out_exc_val);
        end
        rst = 1'b0;
    endtask

    task automatic test_sequential;
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({out_valid, out_pc, out_instr, out_exc_en}
                !== {1'b1, 64'(4 * i), mem[i], 1'b0}) begin
                errors++;
                $display("FAIL seq_%0d got v%b pc %h instr %h exp pc %h instr %h",
                         i, out_valid, out_pc, out_instr, 4 * i, mem[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        redirect_en = 1'b1;
        redirect_pc = 64'h0;
        tick();
        redirect_en = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({out_valid, out_pc, out_instr, mem_addr}
                !== {1'b1, 64'h4, mem[1], 64'h8}) begin
                errors++;
                $display("FAIL bp_hold_%0d got v%b pc %h instr %h addr %h",
                         i, out_valid, out_pc, out_instr, mem_addr);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, 64'h8, mem[2]}) begin
            errors++;
            $display("FAIL bp_release got v%b pc %h instr %h exp 8 %h",
                     out_valid, out_pc, out_instr, mem[2]);
        end
    endtask

    task automatic test_access_fault;
        redirect_en = 1'b1;
        redirect_pc = 64'h1FFC;
        tick();
        redirect_en = 1'b0;
        tick();
        checks++;
        if ({out_valid, out_pc, out_instr, out_exc_en}
            !== {1'b1, 64'h1FFC, mem[2047], 1'b0}) begin
            errors++;
            $display("FAIL last_word got v%b pc %h instr %h exc %b",
                     out_valid, out_pc, out_instr, out_exc_en);
        end
        tick();
        checks++;
        if ({out_valid, out_pc, out_instr, out_exc_en, out_exc_code,
             out_exc_val}
            !== {1'b1, 64'h2000, 32'h13, 1'b1, 4'd1, 64'h2000}) begin
            errors++;
            $display("FAIL access_fault got v%b pc %h instr %h exc %b/%h/%h",
                     out_valid, out_pc, out_instr, out_exc_en,
                     out_exc_code, out_exc_val);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({out_valid, mem_addr} !== {1'b0, 64'h2000}) begin
                errors++;
                $display("FAIL parked_%0d got v%b addr %h exp 0 2000",
                         i, out_valid, mem_addr);
            end
        end
    endtask

    task automatic test_misaligned;
        redirect_en = 1'b1;
        redirect_pc = 64'h6;
        tick();
        redirect_en = 1'b0;
        tick();
        checks++;
        if ({out_valid, out_instr, out_exc_en, out_exc_code, out_exc_val}
            !== {1'b1, 32'h13, 1'b1, 4'd0, 64'h6}) begin
            errors++;
            $display("FAIL misaligned got v%b instr %h exc %b/%h/%h",
                     out_valid, out_instr, out_exc_en, out_exc_code,
                     out_exc_val);
        end
        redirect_en = 1'b1;
        redirect_pc = 64'h10;
        tick();
        redirect_en = 1'b0;
        checks++;
        if ({out_valid, mem_addr} !== {1'b0, 64'h10}) begin
            errors++;
            $display("FAIL unpark_n1 got v%b addr %h exp 0 10",
                     out_valid, mem_addr);
        end
        tick();
        checks++;
        if ({out_valid, out_pc, out_instr, out_exc_en}
            !== {1'b1, 64'h10, mem[4], 1'b0}) begin
            errors++;
            $display("FAIL unpark_n2 got v%b pc %h instr %h exc %b",
                     out_valid, out_pc, out_instr, out_exc_en);
        end
    endtask

    task automatic test_redirect_handshake;
        tick();
        redirect_en = 1'b1;
        redirect_pc = 64'h40;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rh_pre got v%b exp 1", out_valid);
        end
        tick();
        redirect_en = 1'b0;
        checks++;
        if ({out_valid, mem_addr} !== {1'b0, 64'h40}) begin
            errors++;
            $display("FAIL rh_flush got v%b addr %h exp 0 40",
                     out_valid, mem_addr);
        end
        tick();
        checks++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, 64'h40, mem[16]}) begin
            errors++;
            $display("FAIL rh_new got v%b pc %h instr %h",
                     out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_async_reset;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, mem_addr, out_pc} !== {1'b0, 64'h0, 64'h0}) begin
            errors++;
            $display("FAIL async_rst got v%b addr %h pc %h",
                     out_valid, mem_addr, out_pc);
        end
        tick();
        #2 rst = 1'b0;
        tick();
        checks++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, 64'h0, mem[0]}) begin
            errors++;
            $display("FAIL async_resume got v%b pc %h instr %h",
                     out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_random;
        rst = 1'b1;
        #1 rst = 1'b0;
        m_pc     = 64'h0;
        m_valid  = 1'b0;
        m_parked = 1'b0;
        m_e      = '{pc: 64'h0, instr: 32'h13, exc_en: 1'b0,
                     code: 4'h0, val: 64'h0};
        for (int n = 0; n < 400; n++) begin
            fetch_en    = $urandom_range(0, 9) < 8;
            out_ready   = $urandom_range(0, 9) < 7;
            redirect_en = $urandom_range(0, 99) < 8;
            case ($urandom_range(0, 3))
                0: redirect_pc = 64'($urandom_range(0, 2047)) << 2;
                1: redirect_pc = 64'h1FF0 + 64'($urandom_range(0, 5)) * 4;
                2: redirect_pc = 64'($urandom_range(0, 255));
                default: redirect_pc = {$urandom, $urandom};
            endcase
            if (redirect_en) begin
                m_pc     = redirect_pc;
                m_valid  = 1'b0;
                m_parked = 1'b0;
            end else if (!m_parked && fetch_en && (!m_valid || out_ready)) begin
                m_e     = fetch_of(m_pc);
                m_valid = 1'b1;
                if (m_e.exc_en) m_parked = 1'b1;
                else m_pc = m_pc + 4;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            tick();
            checks++;
            if ({out_valid, mem_addr} !== {m_valid, m_pc}) begin
                errors++;
                $display("FAIL rnd_%0d_ctl got v%b addr %h exp v%b addr %h",
                         n, out_valid, mem_addr, m_valid, m_pc);
            end
            checks++;
            if ({out_pc, out_instr, out_exc_en, out_exc_code, out_exc_val}
                !== m_e) begin
                errors++;
                $display("FAIL rnd_%0d_entry got %h/%h/%b/%h/%h exp %h/%h/%b/%h/%h",
                         n, out_pc, out_instr, out_exc_en, out_exc_code,
                         out_exc_val, m_e.pc, m_e.instr, m_e.exc_en,
                         m_e.code, m_e.val);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < MEM_SIZE; i++) mem[i] = $urandom;
        test_reset();
        test_sequential();
        test_backpressure();
        test_access_fault();
        test_misaligned();
        test_redirect_handshake();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller that sequences the instruction memory. It owns the fetch PC and drives the memory's combinational read address. It registers each fetched word, together with its PC and any fetch exception, into a single-entry valid/ready output stage for decode. It also handles redirects from branch and trap logic, and parks after an access fault until software redirects it.

## Interface
- RESET_PC, 64'h0: fetch PC loaded on reset.
- MEM_SIZE, 2048: instruction memory depth in 32-bit words; word index ≥ MEM_SIZE faults.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- fetch_en  in  1  when low, no new fetch is launched; the held output entry is unaffected.
- redirect_en  in  1  one-cycle pulse; load redirect_pc and flush the output stage.
- redirect_pc  in  64  new fetch PC.
- mem_addr  out  64  read address to instruction memory, equals fetch_pc.
- mem_instr  in  32  instruction word returned combinationally for mem_addr in the same cycle.
- out_valid  out  1  output entry valid.
- out_ready  in  1  decode accepts the entry when out_valid && out_ready.
- out_pc  out  64  PC of the entry.
- out_instr  out  32  instruction word; 32'h00000013 (NOP) on a fault.
- out_exc_en  out  1  entry carries a fetch exception.
- out_exc_code  out  4  0 = instruction address misaligned, 1 = instruction access fault.
- out_exc_val  out  64  faulting PC (MTVAL), 0 when no fault.

## Operation
- State machine with two states: RUN and PARKED. Reset enters RUN.
- Reset values:
  - fetch_pc = RESET_PC, out_valid = 0, out_pc = 0, out_instr = 32'h00000013.
  - out_exc_en = 0, out_exc_code = 0, out_exc_val = 0.
- Load condition: state == RUN && fetch_en && (!out_valid || out_ready) && !redirect_en.
- On load, the output register captures the entry and out_valid = 1:
  - Misaligned (fetch_pc[1:0] != 0): NOP, exc_en = 1, code 0, exc_val = fetch_pc; state → PARKED; fetch_pc unchanged.
  - Out of range (fetch_pc[63:2] ≥ MEM_SIZE): NOP, exc_en = 1, code 1, exc_val = fetch_pc; state → PARKED; fetch_pc unchanged.
  - Misaligned takes priority over out of range.
  - Otherwise: out_instr = mem_instr, out_pc = fetch_pc, exc fields 0; fetch_pc += 4, modulo 2^64, wrapping silently.
- Acceptance without a load (out_valid && out_ready and the load condition false) clears out_valid.
- PARKED: the fault entry is held until accepted, then out_valid = 0. No further fetches until redirect_en.
- A fault is reported exactly once per faulting PC; it is never re-emitted while PARKED.
- Redirect has highest priority, in any state:
  - fetch_pc ← redirect_pc, out_valid ← 0, state ← RUN.
  - A handshake in the same cycle counts as a flush, not a consumption.
- Word index MEM_SIZE−1 is fetched normally; MEM_SIZE faults.

## Timing
- mem_addr is a pure function of the fetch_pc register; no combinational path from any input to mem_addr.
- Outputs out_* are registered; out_valid depends only on state registers.
- Fetch throughput is one entry per cycle while out_ready is held high.
- Redirect latency:
  - redirect_en high in cycle N.
  - Cycle N+1: mem_addr = redirect_pc.
  - Cycle N+2: out_valid = 1 with out_pc = redirect_pc.
- Back-pressure: while out_valid && !out_ready, all out_* fields are stable and fetch_pc does not advance.
- rst asserted mid-operation: all registers go to their reset values immediately (asynchronous); the in-flight entry is lost. Fetch resumes at RESET_PC the first cycle after deassertion.

## Test plan
- Sequential fetch: reset, RESET_PC = 0, memory words 0..3 = A, B, C, D, out_ready = 1 → out_valid from cycle 1; entries (0,A), (4,B), (8,C), (0xC,D) on consecutive cycles.
- Back-pressure: out_ready low for 3 cycles while holding (4,B) → out_pc/out_instr stable, mem_addr stays 8. On release, (8,C) follows the next cycle.
- Access fault: redirect to 0x1FFC then continue → entry (0x1FFC, word 2047), then fault entry code 1, exc_val 0x2000, instr 0x13. Then out_valid = 0 indefinitely until redirect.
- Misaligned redirect: redirect_pc = 0x6 → fault entry code 0, exc_val 0x6. A following redirect to 0x10 yields (0x10, word 4) two cycles later.
- Redirect with handshake: redirect_en and out_ready both high while out_valid → entry flushed; out_valid = 0 next cycle; new PC appears at N+2.
- Async reset mid-stream: rst pulsed between clock edges → out_valid drops immediately; first entry after release is (RESET_PC, word 0).
